// File: rtl/first_nios2_system_nios2_gen2_0_cpu_mul_seq.sv
// Sequential 32x32 multiplier on one 16x16 array: MUL/MULXUU/MULXSU/MULXSS.
// Five cycles from accepted start to done; en=0 freezes everything for that cycle.
module first_nios2_system_nios2_gen2_0_cpu_mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] E_src1,
  input  logic [31:0] E_src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P1   = 3'd2,
    S_P2   = 3'd3,
    S_P3   = 3'd4,
    S_FIX  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [63:0] acc;
  logic [31:0] pp;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_prod;
  logic [63:0] full;
  logic [31:0] corr_a, corr_b, hi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_P0;
        S_P0:    state_nxt = S_P1;
        S_P1:    state_nxt = S_P2;
        S_P2:    state_nxt = S_P3;
        S_P3:    state_nxt = S_FIX;
        S_FIX:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // Partial-product order: lo*lo, lo(A)*hi(B), hi(A)*lo(B), hi*hi.
  always_comb begin
    mul_a    = (state == S_P0 || state == S_P1) ? a_q[15:0] : a_q[31:16];
    mul_b    = (state == S_P0 || state == S_P2) ? b_q[15:0] : b_q[31:16];
    mul_prod = {16'b0, mul_a} * {16'b0, mul_b};
  end

  // Unsigned product, then subtract the sign-weight terms for signed operands.
  always_comb begin
    full   = acc + {pp, 32'b0};
    corr_a = (op_q[1] && a_q[31]) ? b_q : 32'b0;
    corr_b = (op_q == 2'b11 && b_q[31]) ? a_q : 32'b0;
    hi     = full[63:32] - corr_a - corr_b;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= 32'b0;
      b_q    <= 32'b0;
      op_q   <= 2'b0;
      acc    <= 64'b0;
      pp     <= 32'b0;
      done   <= 1'b0;
      result <= 32'b0;
    end else if (en) begin
      pp   <= mul_prod;
      done <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q  <= E_src1;
            b_q  <= E_src2;
            op_q <= op;
            acc  <= 64'b0;
          end
        end
        S_P1:        acc <= {32'b0, pp};
        S_P2, S_P3:  acc <= acc + {16'b0, pp, 16'b0};
        S_FIX:       result <= (op_q == 2'b00) ? full[31:0] : hi;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_first_nios2_system_nios2_gen2_0_cpu_mul_seq.sv
// Scoreboard bench: expected word and done cycle queued at issue, popped on each done pulse.
module tb_first_nios2_system_nios2_gen2_0_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        start;
  logic [1:0]  op;
  logic [31:0] E_src1, E_src2;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        done_q = 1'b0;
  logic [31:0] last_res = 32'b0;

  first_nios2_system_nios2_gen2_0_cpu_mul_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .start   (start),
    .op      (op),
    .E_src1  (E_src1),
    .E_src2  (E_src2),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  // Reference via sign/zero-extended 64-bit product.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    sa = o[1]       ? {{32{a[31]}}, a} : {32'b0, a};
    sb = (o == 2'd3) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = sa * sb;
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      done_q   = 1'b0;
      last_res = 32'b0;
    end else begin
      if (done && !done_q) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("result", result, e.res);
          check("done_cycle", cyc, e.cyc);
          last_res = e.res;
        end
      end else begin
        check("result_held", result, last_res);
      end
      done_q = done;
    end
  end

  // Call #1 after a rising edge; returns #1 after the edge that sampled start.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int lat);
    exp_t e;
    start  = 1'b1;
    op     = o;
    E_src1 = a;
    E_src2 = b;
    @(posedge clk);
    #1;
    e.res = expv;
    e.cyc = cyc + lat;
    sb_q.push_back(e);
    start  = 1'b0;
    op     = 2'($urandom_range(0, 3));
    E_src1 = $urandom;
    E_src2 = $urandom;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          n;

    reset_n = 1'b0;
    en      = 1'b1;
    start   = 1'b0;
    op      = 2'b0;
    E_src1  = 32'b0;
    E_src2  = 32'b0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    idle_cycles(3);
    reset_n = 1'b1;
    idle_cycles(2);

    // Basic MUL with busy window
    issue(2'b00, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("busy_window", busy, (i < 5) ? 1 : 0);
    end
    #1;
    wait_drain(20);

    // Corner operands
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5);
    wait_drain(20);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    wait_drain(20);
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5);
    wait_drain(20);
    issue(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5);
    wait_drain(20);
    issue(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 5);
    wait_drain(20);

    // Three-cycle stall in P2 plus a start pulse while busy
    issue(2'b00, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 8);
    idle_cycles(2);
    en     = 1'b0;
    start  = 1'b1;
    op     = 2'b01;
    E_src1 = 32'hDEAD_BEEF;
    E_src2 = 32'h1234_5678;
    idle_cycles(3);
    en = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    wait_drain(20);
    idle_cycles(10);

    // Reset during P3 aborts the op
    issue(2'b01, 32'hCAFE_F00D, 32'h7654_3210, model(2'b01, 32'hCAFE_F00D, 32'h7654_3210), 5);
    idle_cycles(3);
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle_cycles(8);
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 5);
    wait_drain(20);

    // Back-to-back: second start in the done cycle
    issue(2'b10, 32'h8765_4321, 32'h0000_FFFF, model(2'b10, 32'h8765_4321, 32'h0000_FFFF), 5);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_done_seen", done, 1);
    issue(2'b11, 32'h7FFF_FFFF, 32'h8000_0001, model(2'b11, 32'h7FFF_FFFF, 32'h8000_0001), 5);
    wait_drain(20);

    // Random operands over all ops
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      issue(ro, ra, rb, model(ro, ra, rb), 5);
      wait_drain(20);
    end
    idle_cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
